player_motion_ctl: RTL and testbench

PLAYER_MOTION_CTL -- requirements
Module: player_motion_ctl

---
 rtl/player_motion_ctl.sv | 158 +++++++++++++++
 tb/tb_player_motion_ctl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctl.sv
// Sprite motion controller: per-frame horizontal stepping plus a jump/gravity state machine.
// Latency: updates happen on the vsync rising-edge cycle and are visible on outputs the next cycle.
// Backpressure: none; inputs are level-sampled, and a jump edge is held only until the next frame tick.
module player_motion_ctl #(
    parameter int X_INIT  = 376,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 752,
    parameter int Y_FLOOR = 536,
    parameter int STEP    = 4,
    parameter int JUMP_V  = 16,
    parameter int GRAVITY = 1,
    parameter int V_MAX   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10,
        UNUSED = 2'b11
    } motion_t;

    localparam logic [11:0] X_INIT_V  = 12'(X_INIT);
    localparam logic [11:0] X_MIN_V   = 12'(X_MIN);
    localparam logic [11:0] X_MAX_V   = 12'(X_MAX);
    localparam logic [11:0] Y_FLOOR_V = 12'(Y_FLOOR);
    localparam logic [11:0] STEP_V    = 12'(STEP);
    localparam logic [7:0]  JUMP_V8   = 8'(JUMP_V);
    localparam logic [7:0]  GRAV_V8   = 8'(GRAVITY);
    localparam logic [7:0]  VMAX_V8   = 8'(V_MAX);

    motion_t     st_q;
    motion_t     st_d;
    logic [11:0] x_d;
    logic [11:0] y_d;
    logic [7:0]  vel_q;
    logic [7:0]  vel_d;
    logic        vs_d;
    logic        up_d;
    logic        jump_req;
    logic        tick;
    logic [12:0] y_sum;
    logic [8:0]  vel_sum;

    // One tick per frame: the cycle vsync goes high (reset clears vs_d, so a high level at release counts).
    assign tick  = vsync_in & ~vs_d;
    assign state = st_q;

    // Edge-detect history and the single-frame jump request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d     <= 1'b0;
            up_d     <= 1'b0;
            jump_req <= 1'b0;
        end else begin
            vs_d <= vsync_in;
            up_d <= up;
            if (tick) begin
                jump_req <= 1'b0;
            end else if (up && !up_d) begin
                jump_req <= 1'b1;
            end
        end
    end

    // Next-state for position, velocity and motion state; everything holds except on a tick.
    always_comb begin
        st_d    = st_q;
        x_d     = x_pos;
        y_d     = y_pos;
        vel_d   = vel_q;
        // Widened sums so the floor and velocity-cap comparisons cannot wrap.
        y_sum   = {1'b0, y_pos} + {5'b0, vel_q};
        vel_sum = {1'b0, vel_q} + {1'b0, GRAV_V8};

        if (tick) begin
            // Horizontal motion applies in every vertical state; conflicting keys cancel.
            if (left && !right) begin
                if ({1'b0, x_pos} < ({1'b0, X_MIN_V} + {1'b0, STEP_V})) begin
                    x_d = X_MIN_V;
                end else begin
                    x_d = x_pos - STEP_V;
                end
            end else if (right && !left) begin
                if (({1'b0, x_pos} + {1'b0, STEP_V}) > {1'b0, X_MAX_V}) begin
                    x_d = X_MAX_V;
                end else begin
                    x_d = x_pos + STEP_V;
                end
            end

            case (st_q)
                GROUND: begin
                    // Launch only from the ground; y moves starting next frame.
                    if (jump_req) begin
                        vel_d = JUMP_V8;
                        st_d  = RISE;
                    end
                end
                RISE: begin
                    if (y_pos < {4'b0, vel_q}) begin
                        // Would cross the top of the screen: pin to 0 and start falling.
                        y_d   = '0;
                        vel_d = '0;
                        st_d  = FALL;
                    end else begin
                        y_d = y_pos - {4'b0, vel_q};
                        if (vel_q <= GRAV_V8) begin
                            vel_d = '0;
                            st_d  = FALL;
                        end else begin
                            vel_d = vel_q - GRAV_V8;
                        end
                    end
                end
                FALL: begin
                    if (y_sum >= {1'b0, Y_FLOOR_V}) begin
                        y_d   = Y_FLOOR_V;
                        vel_d = '0;
                        st_d  = GROUND;
                    end else begin
                        y_d   = y_sum[11:0];
                        vel_d = (vel_sum > {1'b0, VMAX_V8}) ? VMAX_V8 : vel_sum[7:0];
                    end
                end
                default: begin
                    // Illegal encoding: fall back to gravity so the sprite lands cleanly.
                    st_d = FALL;
                end
            endcase
        end
    end

    // Registered outputs and velocity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= X_INIT_V;
            y_pos <= Y_FLOOR_V;
            vel_q <= '0;
            st_q  <= GROUND;
        end else begin
            x_pos <= x_d;
            y_pos <= y_d;
            vel_q <= vel_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl with hand-computed positions.
// Each frame is one vsync pulse; outputs are sampled on the falling clock edge.
// Inputs are changed on falling edges only, away from the active edge.
module tb_player_motion_ctl;

    logic        clk;
    logic        rst_n;
    logic        vsync_in;
    logic        left;
    logic        right;
    logic        up;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    player_motion_ctl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .left     (left),
        .right    (right),
        .up       (up),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int es);
        check({tag, ".x"}, int'(x_pos), ex);
        check({tag, ".y"}, int'(y_pos), ey);
        check({tag, ".st"}, int'(state), es);
    endtask

    // One frame: vsync high for one cycle, then low.
    task automatic frame_tick();
        @(negedge clk) vsync_in = 1'b1;
        @(negedge clk) vsync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame_tick();
    endtask

    task automatic pulse_up();
        @(negedge clk) up = 1'b1;
        @(negedge clk) up = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        vsync_in = 1'b0;
        left     = 1'b0;
        right    = 1'b0;
        up       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int jumps;
    int prev_st;

    initial begin
        rst_n    = 1'b0;
        vsync_in = 1'b0;
        left     = 1'b0;
        right    = 1'b0;
        up       = 1'b0;

        // Reset values
        do_reset();
        check_pos("reset", 376, 536, 0);

        // Walk right: +4 per frame, nothing moves between frames
        right = 1'b1;
        frame_tick();
        check("right1.x", int'(x_pos), 380);
        frames(9);
        check_pos("right10", 416, 536, 0);
        // vsync held high for several cycles is still one frame
        @(negedge clk) vsync_in = 1'b1;
        repeat (5) @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        check("long_vsync.x", int'(x_pos), 420);
        right = 1'b0;

        // Saturation at both walls
        do_reset();
        left = 1'b1;
        frames(100);
        check("left_sat.x", int'(x_pos), 0);
        left  = 1'b0;
        right = 1'b1;
        frames(200);
        check("right_sat.x", int'(x_pos), 752);
        right = 1'b0;

        // Single jump: 1 launch frame, 16 rising frames, 17 falling frames
        do_reset();
        pulse_up();
        frame_tick();
        check_pos("launch", 376, 536, 1);
        frame_tick();
        check("rise1.y", int'(y_pos), 520);
        frames(15);
        check_pos("apex", 376, 400, 2);
        frame_tick();
        check("fall1.y", int'(y_pos), 400);
        frame_tick();
        check("fall2.y", int'(y_pos), 401);
        // Jump pressed mid-air is dropped, not buffered until landing
        pulse_up();
        frames(15);
        check_pos("land", 376, 536, 0);
        frames(3);
        check_pos("no_buffered_jump", 376, 536, 0);

        // Held up: exactly one jump
        do_reset();
        up      = 1'b1;
        jumps   = 0;
        prev_st = 0;
        for (int i = 0; i < 100; i++) begin
            frame_tick();
            if (prev_st == 0 && state == 2'b01) jumps++;
            prev_st = int'(state);
        end
        check("held_up.jumps", jumps, 1);
        check_pos("held_up.end", 376, 536, 0);
        up = 1'b0;

        // Asynchronous reset in the middle of a jump
        do_reset();
        pulse_up();
        frames(8);
        check_pos("jump8", 376, 445, 1);
        #2 rst_n = 1'b0;
        #1;
        check_pos("async_rst", 376, 536, 0);
        @(negedge clk) rst_n = 1'b1;
        frames(5);
        check_pos("after_rst_idle", 376, 536, 0);

        // vsync already high when reset releases counts as a frame edge
        @(negedge clk);
        rst_n    = 1'b0;
        vsync_in = 1'b1;
        right    = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("vs_high_release.x", int'(x_pos), 380);
        vsync_in = 1'b0;
        right    = 1'b0;

        // Both keys during a jump: x frozen, same trajectory
        do_reset();
        left  = 1'b1;
        right = 1'b1;
        pulse_up();
        frame_tick();
        check_pos("both.launch", 376, 536, 1);
        frames(16);
        check_pos("both.apex", 376, 400, 2);
        frames(17);
        check_pos("both.land", 376, 536, 0);
        left  = 1'b0;
        right = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
